shift_deser: RTL and testbench



---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_deser.sv | 88 ++++++++
 tb/tb_shift_deser.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial deserializer family.
package shift_pkg;

  // Bit order of a word on the serial line.
  typedef enum logic {
    MODE_MSB_FIRST = 1'b0,
    MODE_LSB_FIRST = 1'b1
  } bit_order_e;

  // Bit-counter width for a W-bit word (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with runtime bit order and a 1-entry
// valid/ready holding register.
//   clk, reset_n         : clock, async active-low reset
//   bit_in, shift        : serial bit and its qualifier
//   sync                 : word-boundary marker, aborts a partial word
//   lsb_first            : bit order, latched on the first bit of each word
//   word_out, word_valid : holding register and its occupancy flag
//   word_ready           : consumer accept
//   overrun, ovr_clr     : sticky dropped-word flag and its clear
//   bit_cnt              : bits accepted in the current partial word
module shift_deser
  import shift_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned CW = cnt_w(W)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          bit_in,
  input  logic          shift,
  input  logic          sync,
  input  logic          lsb_first,
  output logic [W-1:0]  word_out,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic [CW-1:0] bit_cnt
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next_c;
  bit_order_e    mode_q;
  bit_order_e    mode_eff_c;
  logic [CW-1:0] ec_c;
  logic          complete_c;
  logic          hold_free_c;

  // Effective count, bit order for this shift, and completion/acceptance.
  always_comb begin
    ec_c        = sync ? '0 : bit_cnt;
    mode_eff_c  = (ec_c == '0) ? bit_order_e'(lsb_first) : mode_q;
    sr_next_c   = sr;
    if (shift) begin
      if (mode_eff_c == MODE_LSB_FIRST) sr_next_c = {bit_in, sr[W-1:1]};
      else                              sr_next_c = {sr[W-2:0], bit_in};
    end
    complete_c  = shift && (ec_c == LAST);
    hold_free_c = !word_valid || word_ready;
  end

  // Shift register, bit counter and latched bit order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      mode_q  <= MODE_MSB_FIRST;
    end else if (shift) begin
      sr      <= sr_next_c;
      bit_cnt <= (ec_c == LAST) ? '0 : ec_c + CW'(1);
      if (ec_c == '0) mode_q <= mode_eff_c;
    end else if (sync) begin
      bit_cnt <= '0;
    end
  end

  // Holding register: load on completion when free, else drop and flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete_c && hold_free_c) begin
        word_out   <= sr_next_c;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      // Set wins over clear in the same cycle.
      if (complete_c && !hold_free_c) overrun <= 1'b1;
      else if (ovr_clr)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
module tb_shift_deser;

  logic       clk;
  logic       reset_n;
  logic       bit_in;
  logic       shift;
  logic       sync;
  logic       lsb_first;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       overrun;
  logic       ovr_clr;
  logic [2:0] bit_cnt;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  shift_deser #(.W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bit_in     (bit_in),
    .shift      (shift),
    .sync       (sync),
    .lsb_first  (lsb_first),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .bit_cnt    (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs were set before the call, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word, one bit per clock, in the given order (stimulus only).
  task automatic send_word(input logic [7:0] w, input logic lsb);
    lsb_first = lsb;
    for (int i = 0; i < 8; i++) begin
      bit_in = lsb ? w[i] : w[7-i];
      shift  = 1'b1;
      step();
    end
    shift = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bit_in = 1'b0; shift = 1'b0; sync = 1'b0;
    lsb_first = 1'b0; word_ready = 1'b0; ovr_clr = 1'b0;
    #3;
    n_checks++;
    if ({word_out, word_valid, overrun, bit_cnt} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h v=%b ovr=%b cnt=%0d, want all 0",
               word_out, word_valid, overrun, bit_cnt);
    end
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits;
    bits = 8'b0100_1101;  // bits[i] is the i-th bit sent: 1,0,1,1,0,0,1,0
    word_ready = 1'b1;
    lsb_first  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_in = bits[i];
      shift  = 1'b1;
      if (i == 7) exp_q.push_back(8'h4D);
      step();
      n_checks++;
      if (bit_cnt !== 3'((i + 1) % 8)) begin
        n_fail++;
        $display("FAIL lsb_bit_cnt[%0d]: got %0d, want %0d", i, bit_cnt, (i + 1) % 8);
      end
    end
    shift = 1'b0;
    n_checks++;
    if (word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_valid: got %b, want 1", word_valid);
    end else begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL lsb_sb_empty: got empty queue, want entry");
      end else begin
        exp_w = exp_q.pop_front();
        if (word_out !== exp_w) begin
          n_fail++; $display("FAIL lsb_word: got %h, want %h", word_out, exp_w);
        end
      end
    end
    step();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++; $display("FAIL lsb_drain: got valid=%b, want 0", word_valid);
    end
  endtask

  task automatic test_msb_first_toggle();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lsb_first = (i >= 3 && i <= 5);  // mid-word toggles must be ignored
      bit_in    = bits[i];
      shift     = 1'b1;
      if (i == 7) exp_q.push_back(8'hB2);
      step();
    end
    shift = 1'b0; lsb_first = 1'b0;
    n_checks++;
    if (exp_q.size() == 0 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL msb_valid: got valid=%b q=%0d, want 1 and entry", word_valid, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (word_out !== exp_w) begin
        n_fail++; $display("FAIL msb_word: got %h, want %h", word_out, exp_w);
      end
    end
    step();
  endtask

  task automatic test_overrun();
    word_ready = 1'b0;
    exp_q.push_back(8'h4D);
    send_word(8'h4D, 1'b1);
    send_word(8'hFF, 1'b1);  // dropped: holding register busy
    n_checks++;
    if (overrun !== 1'b1 || word_valid !== 1'b1 || word_out !== 8'h4D) begin
      n_fail++;
      $display("FAIL ovr_set: got ovr=%b v=%b out=%h, want 1 1 4d", overrun, word_valid, word_out);
    end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_clr: got ovr=%b v=%b, want 0 1", overrun, word_valid);
    end
    word_ready = 1'b1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL ovr_sb_empty: got empty queue, want entry");
    end else begin
      exp_w = exp_q.pop_front();
      if (word_out !== exp_w) begin
        n_fail++; $display("FAIL ovr_word: got %h, want %h", word_out, exp_w);
      end
    end
    step();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_drain: got valid=%b, want 0", word_valid);
    end
  endtask

  task automatic test_ready_at_completion();
    logic [7:0] w2;
    w2 = 8'hA5;
    word_ready = 1'b0;
    send_word(8'h3C, 1'b1);
    lsb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_in     = w2[7-i];
      shift      = 1'b1;
      word_ready = (i == 7);  // 3C consumed in the very cycle A5 completes
      if (i == 7) exp_q.push_back(w2);
      step();
    end
    shift = 1'b0; word_ready = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_flags: got ovr=%b v=%b, want 0 1", overrun, word_valid);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL b2b_sb_empty: got empty queue, want entry");
    end else begin
      exp_w = exp_q.pop_front();
      if (word_out !== exp_w) begin
        n_fail++; $display("FAIL b2b_word: got %h, want %h", word_out, exp_w);
      end
    end
    step();
    n_checks++;
    if (word_valid !== 1'b1 || word_out !== w2) begin
      n_fail++; $display("FAIL b2b_hold: got v=%b out=%h, want 1 %h", word_valid, word_out, w2);
    end
    word_ready = 1'b1;
    step();
  endtask

  task automatic test_sync();
    logic [7:0] w;
    w = 8'h35;
    word_ready = 1'b1;
    lsb_first  = 1'b1;
    // sync with shift=0 clears the count
    bit_in = 1'b1; shift = 1'b1; step(); step();
    shift = 1'b0; sync = 1'b1; step(); sync = 1'b0;
    n_checks++;
    if (bit_cnt !== 3'd0) begin
      n_fail++; $display("FAIL sync_noshift_cnt: got %0d, want 0", bit_cnt);
    end
    // three junk bits, then the word starting on a sync+shift cycle
    for (int i = 0; i < 3; i++) begin bit_in = 1'b0; shift = 1'b1; step(); end
    for (int i = 0; i < 8; i++) begin
      bit_in = w[i];
      shift  = 1'b1;
      sync   = (i == 0);
      if (i == 7) exp_q.push_back(w);
      step();
      sync = 1'b0;
      if (i == 0) begin
        n_checks++;
        if (bit_cnt !== 3'd1) begin
          n_fail++; $display("FAIL sync_cnt: got %0d, want 1", bit_cnt);
        end
      end
      if (i == 4) begin  // 8th bit since the junk started: must not complete
        n_checks++;
        if (word_valid !== 1'b0) begin
          n_fail++; $display("FAIL sync_early_word: got valid=%b, want 0", word_valid);
        end
      end
    end
    shift = 1'b0;
    n_checks++;
    if (exp_q.size() == 0 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL sync_valid: got valid=%b q=%0d, want 1 and entry", word_valid, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (word_out !== exp_w) begin
        n_fail++; $display("FAIL sync_word: got %h, want %h", word_out, exp_w);
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    word_ready = 1'b0;
    send_word(8'h5A, 1'b1);
    for (int i = 0; i < 5; i++) begin bit_in = 1'b1; shift = 1'b1; step(); end
    shift = 1'b0;
    n_checks++;
    if (bit_cnt !== 3'd5 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got cnt=%0d v=%b, want 5 1", bit_cnt, word_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({word_out, word_valid, overrun, bit_cnt} !== 13'h0) begin
      n_fail++;
      $display("FAIL arst_state: got out=%h v=%b ovr=%b cnt=%0d, want all 0",
               word_out, word_valid, overrun, bit_cnt);
    end
    #1 reset_n = 1'b1;
    word_ready = 1'b1;
    exp_q.push_back(8'hC6);
    send_word(8'hC6, 1'b0);
    n_checks++;
    if (exp_q.size() == 0 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_valid: got valid=%b q=%0d, want 1 and entry", word_valid, exp_q.size());
    end else begin
      exp_w = exp_q.pop_front();
      if (word_out !== exp_w) begin
        n_fail++; $display("FAIL arst_word: got %h, want %h", word_out, exp_w);
      end
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lsb_first();
    test_msb_first_toggle();
    test_overrun();
    test_ready_at_completion();
    test_sync();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
